sort_job_ctrl: RTL and testbench
================================

// Module: sort_job_ctrl
// PURPOSE
//  Sequencer for the 8-input descending insertion-sort datapath (ins).
//  - Collects 8 words from a serial valid/ready stream and drives them in parallel onto the sorter.
//  - Waits the sorter's fixed pipeline latency, then captures the sorted result.
//  - Streams the result out serially, largest first, with a last flag.
//  - Sits between a serial producer/consumer and one sorter instance.
// PARAMETERS
//  W        32  data word width
//  N        8   words per job (fixed by sorter; other values unsupported)
//  SORT_LAT 2   clk cycles from stable srt_in to valid srt_out
// PORTS
//  clk        in   1    single clock, all logic on posedge
//  rst_n      in   1    synchronous active-low reset
//  in_valid   in   1    producer word valid
//  in_data    in   W    producer word
//  in_ready   out  1    controller can accept a word
//  srt_in     out  N*W  to sorter; slice k = in(k+1); first accepted word -> slice 0
//  srt_out    in   N*W  from sorter; slice 0 = out1 = largest
//  out_valid  out  1    sorted word valid
//  out_data   out  W    sorted word
//  out_last   out  1    high with the Nth (smallest) output word
//  out_ready  in   1    consumer accepts word
//  busy       out  1    high in WAIT or DRAIN
//  sort_err   out  1    sticky ordering error (SORT_CHECK_EN only, else 0)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=LOAD, counters=0, srt_in=0, out_data=0,
//   out_valid=0, out_last=0, busy=0, sort_err=0, in_ready=1 after reset.
//  Reset mid-job discards all buffered and captured data; no partial output.
//  FSM:
//   LOAD:
//    - in_ready=1.
//    - Transfer on in_valid&in_ready writes slice[wcnt] and increments wcnt.
//    - in_valid low holds wcnt (gaps allowed).
//    - On transfer with wcnt==N-1: wcnt->0, lat_cnt->0, go WAIT.
//   WAIT:
//    - in_ready=0; srt_in held stable; lat_cnt increments every cycle.
//    - When lat_cnt==SORT_LAT-1: register srt_out into obuf, go DRAIN.
//    - First out_valid is therefore SORT_LAT+1 cycles after the 8th transfer.
//   DRAIN:
//    - out_valid=1, out_data=obuf[rcnt].
//    - Transfer on out_valid&out_ready increments rcnt.
//    - out_ready low stalls with data/last held.
//    - out_last=1 when rcnt==N-1; on that transfer: rcnt->0, go LOAD.
//    - in_ready rises the cycle after the last transfer (no load/drain overlap).
//  in_data is ignored outside LOAD. srt_in is not cleared between jobs.
//  Unsigned compares only; no width growth anywhere.
//  Counter widths are $clog2(N) and $clog2(SORT_LAT)+1; no wrap beyond terminal count.
//  SORT_LAT must be >=1.
// CONFIGURATION
//  SORT_CHECK_EN defined:
//   - At capture, checks obuf[k] >= obuf[k+1] for all k.
//   - Any violation sets sort_err; cleared only by reset.
//  SORT_CHECK_EN undefined: no checker logic; sort_err tied 0.
// STRUCTURE
//  Package sort_pkg:
//   - W_DEF, N_DEF, SORT_LAT_DEF.
//   - state enum {LOAD, WAIT, DRAIN}.
//   - word_t typedef.
//  Sub-module sort_order_chk (combinational ordering check):
//   - Instantiated only under SORT_CHECK_EN.
//  The sorter itself is instantiated by the parent, not here.
// TESTING
//  1. Load 42,17,93,25,51,38,64,70 back-to-back
//     -> out 93,70,64,51,42,38,25,17; out_last only on 17; first out_valid 3 cycles after 8th transfer.
//  2. Same job with in_valid toggling 1/0 and out_ready low 3 cycles mid-drain
//     -> identical output order; out_data and out_last held during stall; no word lost or duplicated.
//  3. Duplicates 50,50,30,70,30,70,50,30 then all-25 job back-to-back
//     -> 70,70,50,50,50,30,30,30 then eight 25s; in_ready=0 for the whole of job 1's WAIT and DRAIN.
//  4. rst_n=0 after 5 words loaded, then a full job 0,255,128,64,192,32,224,16
//     -> outputs reset values; then 255,224,192,128,64,32,16,0.
//  5. Sorter model with out1/out2 swapped, SORT_CHECK_EN defined
//     -> sort_err=1 from the capture cycle until reset; undefined -> sort_err stays 0.
//  6. In WAIT, drive in_valid=1 with in_data=999
//     -> no transfer; 999 never appears in the output.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort job controller.
package sort_pkg;

  localparam int unsigned W_DEF        = 32;
  localparam int unsigned N_DEF        = 8;
  localparam int unsigned SORT_LAT_DEF = 2;

  typedef enum logic [1:0] {
    StLoad,
    StWait,
    StDrain
  } state_e;

  typedef logic [W_DEF-1:0] word_t;

endpackage

// File: rtl/sort_order_chk.sv
// Combinational descending-order check over N packed words (slice 0 must be largest).
module sort_order_chk
  import sort_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic [N*W-1:0] data_i,
  output logic           ordered_o
);

  // Flag any adjacent pair where the later word exceeds the earlier one.
  always_comb begin
    ordered_o = 1'b1;
    for (int unsigned k = 0; k + 1 < N; k++) begin
      if (data_i[k*W +: W] < data_i[(k+1)*W +: W]) begin
        ordered_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sort_job_ctrl.sv
// Sequencer around one N-input descending sorter: serial load, fixed-latency wait,
// serial drain (largest first). Optional ordering checker enabled by macro SORT_CHECK_EN;
// without it sort_err_o is tied low.
module sort_job_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned N        = N_DEF,
  parameter int unsigned SORT_LAT = SORT_LAT_DEF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  input  logic [W-1:0]   in_data_i,
  output logic           in_ready_o,
  output logic [N*W-1:0] srt_in_o,
  input  logic [N*W-1:0] srt_out_i,
  output logic           out_valid_o,
  output logic [W-1:0]   out_data_o,
  output logic           out_last_o,
  input  logic           out_ready_i,
  output logic           busy_o,
  output logic           sort_err_o
);

  localparam int unsigned CntW = $clog2(N);
  localparam int unsigned LatW = $clog2(SORT_LAT) + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);
  localparam logic [LatW-1:0] LatLast = LatW'(SORT_LAT - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       wcnt_q, wcnt_d;
  logic [CntW-1:0]       rcnt_q, rcnt_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic [N-1:0][W-1:0]   srt_in_q, srt_in_d;
  logic [N-1:0][W-1:0]   obuf_q, obuf_d;
  logic                  capture;

  assign srt_in_o = srt_in_q;

  // Next-state, counters, buffers and handshake outputs.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    lat_d       = lat_q;
    srt_in_d    = srt_in_q;
    obuf_d      = obuf_q;
    capture     = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    busy_o      = 1'b0;
    out_data_o  = obuf_q[rcnt_q];

    unique case (state_q)
      StLoad: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          srt_in_d[wcnt_q] = in_data_i;
          if (wcnt_q == LastIdx) begin
            wcnt_d  = '0;
            lat_d   = '0;
            state_d = StWait;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StWait: begin
        busy_o = 1'b1;
        if (lat_q == LatLast) begin
          // srt_out has settled for the current srt_in; take a private copy.
          capture = 1'b1;
          obuf_d  = srt_out_i;
          lat_d   = '0;
          state_d = StDrain;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StDrain: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_last_o  = (rcnt_q == LastIdx);
        if (out_ready_i) begin
          if (rcnt_q == LastIdx) begin
            rcnt_d  = '0;
            state_d = StLoad;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StLoad;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      lat_q    <= '0;
      srt_in_q <= '0;
      obuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      lat_q    <= lat_d;
      srt_in_q <= srt_in_d;
      obuf_q   <= obuf_d;
    end
  end

`ifdef SORT_CHECK_EN
  logic ordered;
  logic sort_err_q, sort_err_d;

  sort_order_chk #(
    .W (W),
    .N (N)
  ) u_order_chk (
    .data_i    (srt_out_i),
    .ordered_o (ordered)
  );

  // Sticky error: set on a mis-ordered capture, cleared only by reset.
  always_comb begin
    sort_err_d = sort_err_q | (capture & ~ordered);
  end

  // Error flag register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sort_err_q <= 1'b0;
    end else begin
      sort_err_q <= sort_err_d;
    end
  end

  assign sort_err_o = sort_err_q;
`else
  assign sort_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Self-checking bench for sort_job_ctrl with a behavioural one-stage sorter model.
module tb_sort_job_ctrl;
  import sort_pkg::*;

  localparam int unsigned W  = W_DEF;
  localparam int unsigned N  = N_DEF;
  localparam int          NI = N_DEF;
  localparam int          TO = 200;
`ifdef SORT_CHECK_EN
  localparam logic ERR_ON_SWAP = 1'b1;
`else
  localparam logic ERR_ON_SWAP = 1'b0;
`endif

  typedef word_t job_t [N];
  typedef struct packed {
    word_t data;
    logic  last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  word_t          in_data = '0;
  logic           in_ready;
  logic [N*W-1:0] srt_in;
  logic [N*W-1:0] srt_out = '0;
  logic           out_valid;
  word_t          out_data;
  logic           out_last;
  logic           out_ready = 1'b1;
  logic           busy;
  logic           sort_err;
  logic           swap_en = 1'b0;

  exp_t exp_q[$];
  int   errs = 0;
  int   checks = 0;
  int   xfers = 0;

  always #5 clk = ~clk;

  sort_job_ctrl #(
    .W        (W),
    .N        (N),
    .SORT_LAT (SORT_LAT_DEF)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .srt_in_o    (srt_in),
    .srt_out_i   (srt_out),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .sort_err_o  (sort_err)
  );

  function automatic logic [N*W-1:0] sort_desc(input logic [N*W-1:0] v, input logic swap);
    word_t a[N];
    word_t t;
    int    j;
    logic [N*W-1:0] r;
    for (int i = 0; i < NI; i++) a[i] = v[i*W +: W];
    for (int i = 1; i < NI; i++) begin
      t = a[i];
      j = i;
      while (j > 0 && a[j-1] < t) begin
        a[j] = a[j-1];
        j--;
      end
      a[j] = t;
    end
    if (swap) begin
      t    = a[0];
      a[0] = a[1];
      a[1] = t;
    end
    for (int i = 0; i < NI; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  // Sorter model: one register stage, well inside the controller's wait window.
  always @(posedge clk) srt_out <= sort_desc(srt_in, swap_en);

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: compares the presented word every valid cycle, pops on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check_eq("in_ready_low_in_drain", 32'(in_ready), 0);
      check_eq("busy_in_drain", 32'(busy), 1);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_output_valid", 32'(out_valid), 0);
      end else begin
        check_eq("out_data", out_data, exp_q[0].data);
        check_eq("out_last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  task automatic push_expected(input job_t e);
    for (int i = 0; i < NI; i++) exp_q.push_back('{data: e[i], last: (i == NI - 1)});
  endtask

  task automatic push_word(input word_t d);
    int   n;
    logic ok;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < TO);
    if (!ok) check_eq("push_timeout", 32'(in_ready), 1);
    in_valid = 1'b0;
  endtask

  task automatic send_job(input job_t w, input logic gaps, input logic lat_chk,
                          input logic exp_err);
    for (int i = 0; i < NI; i++) begin
      push_word(w[i]);
      if (gaps && i < NI - 1) begin
        @(posedge clk);
        #1;
      end
    end
    if (lat_chk) begin
      check_eq("lat_valid_c0", 32'(out_valid), 0);
      check_eq("lat_busy_c0", 32'(busy), 1);
      @(posedge clk);
      #1;
      check_eq("lat_valid_c1", 32'(out_valid), 0);
      check_eq("lat_in_ready_c1", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      check_eq("lat_valid_c2", 32'(out_valid), 1);
      check_eq("sort_err_at_capture", 32'(sort_err), 32'(exp_err));
    end
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < TO) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("idle_after_drain", 32'(in_ready), 1);
    check_eq("scoreboard_empty", word_t'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_last", 32'(out_last), 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_sort_err", 32'(sort_err), 0);
    check_eq("rst_srt_in_zero", 32'(srt_in == '0), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t j1, e1, e5, j3a, e3a, j3b, j4, e4;
    j1  = '{42, 17, 93, 25, 51, 38, 64, 70};
    e1  = '{93, 70, 64, 51, 42, 38, 25, 17};
    e5  = '{70, 93, 64, 51, 42, 38, 25, 17};
    j3a = '{50, 50, 30, 70, 30, 70, 50, 30};
    e3a = '{70, 70, 50, 50, 50, 30, 30, 30};
    j3b = '{25, 25, 25, 25, 25, 25, 25, 25};
    j4  = '{0, 255, 128, 64, 192, 32, 224, 16};
    e4  = '{255, 224, 192, 128, 64, 32, 16, 0};

    do_reset();

    // Back-to-back load, latency and ordering.
    xfers = 0;
    push_expected(e1);
    send_job(j1, 1'b0, 1'b1, 1'b0);
    check_eq("srt_in_slice0", srt_in[0 +: W], 42);
    check_eq("srt_in_slice7", srt_in[7*W +: W], 70);
    wait_drained();
    check_eq("xfers_job1", word_t'(xfers), 8);

    // Gapped load and a three-cycle consumer stall mid-drain.
    xfers = 0;
    push_expected(e1);
    send_job(j1, 1'b1, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drained();
    check_eq("xfers_stall", word_t'(xfers), 8);

    // Duplicates followed immediately by a constant job.
    xfers = 0;
    push_expected(e3a);
    send_job(j3a, 1'b0, 1'b0, 1'b0);
    push_expected(j3b);
    send_job(j3b, 1'b0, 1'b0, 1'b0);
    wait_drained();
    check_eq("xfers_dup", word_t'(xfers), 16);

    // Producer pushes 999 during WAIT: must not be accepted.
    push_expected(e1);
    send_job(j1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 999;
    repeat (2) begin
      check_eq("wait_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drained();

    // Reset after a partial load, then a full job.
    for (int i = 0; i < 5; i++) push_word(j4[i]);
    do_reset();
    push_expected(e4);
    send_job(j4, 1'b0, 1'b1, 1'b0);
    wait_drained();

    // Faulty sorter (top two swapped).
    swap_en = 1'b1;
    push_expected(e5);
    send_job(j1, 1'b0, 1'b1, ERR_ON_SWAP);
    wait_drained();
    check_eq("sort_err_sticky", 32'(sort_err), 32'(ERR_ON_SWAP));
    swap_en = 1'b0;
    do_reset();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
